// File: rtl/instr_fetch_exec.sv
// instr_fetch_exec: fetches `count` instructions starting at base_ptr, executes each one and
// hands the results out over a valid/ready port. Define ILLEGAL_OP_CHECK_EN to flag bad ops on err.
module instr_fetch_exec #(
    parameter int ADDR_W = 5,
    parameter int OP_W   = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_ptr,
    input  logic [ADDR_W:0]          count,
    output logic [ADDR_W-1:0]        read_pointer,
    input  logic [4+2*OP_W-1:0]      instruction_word,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic signed [2*OP_W-1:0] result,
    output logic [ADDR_W-1:0]        res_addr,
    output logic                     err,
    output logic                     busy,
    output logic                     done
);
    typedef enum logic [2:0] {IDLE, FETCH, EXEC, OUT, FIN} state_t;
    state_t state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, res_addr_q, res_addr_d;
    logic [ADDR_W:0] rem_q, rem_d;
    logic signed [2*OP_W-1:0] result_q, result_d, a, b, alu;
    logic [3:0] opcode;
    logic illegal, err_q, err_d, valid_q, busy_q, done_q;

    always_comb begin
        opcode = instruction_word[4+2*OP_W-1 -: 4];
        a = {{OP_W{instruction_word[2*OP_W-1]}}, instruction_word[2*OP_W-1 -: OP_W]};
        b = {{OP_W{instruction_word[OP_W-1]}}, instruction_word[OP_W-1:0]};
        // operands are widened first so MULT is full width and MIN/-1 cannot overflow
        illegal = opcode[3] || (opcode[3:1] == 3'b011 && b == '0);
        case (opcode)
            4'd1:    alu = a;
            4'd2:    alu = b;
            4'd3:    alu = a + b;
            4'd4:    alu = a - b;
            4'd5:    alu = a * b;
            4'd6:    alu = a / b;
            4'd7:    alu = a % b;
            default: alu = '0;
        endcase
        state_d    = state_q;
        ptr_d      = ptr_q;
        rem_d      = rem_q;
        result_d   = result_q;
        res_addr_d = res_addr_q;
        err_d      = err_q;
        case (state_q)
            IDLE: if (start) begin
                ptr_d   = base_ptr;
                rem_d   = count;
                state_d = (count == '0) ? FIN : FETCH;
            end
            FETCH: state_d = EXEC;
            EXEC: begin
                result_d   = illegal ? '0 : alu;
                res_addr_d = ptr_q;
`ifdef ILLEGAL_OP_CHECK_EN
                err_d      = illegal;
`else
                err_d      = 1'b0;
`endif
                state_d    = OUT;
            end
            OUT: if (res_ready) begin
                ptr_d   = ptr_q + 1'b1;
                rem_d   = rem_q - 1'b1;
                state_d = (rem_q > (ADDR_W+1)'(1)) ? FETCH : FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            rem_q      <= '0;
            result_q   <= '0;
            res_addr_q <= '0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            result_q   <= result_d;
            res_addr_q <= res_addr_d;
            err_q      <= err_d;
            valid_q    <= state_d == OUT;
            busy_q     <= state_d != IDLE;
            done_q     <= state_d == FIN;
        end
    end

    assign read_pointer = ptr_q;
    assign res_valid    = valid_q;
    assign result       = result_q;
    assign res_addr     = res_addr_q;
    assign err          = err_q;
    assign busy         = busy_q;
    assign done         = done_q;
endmodule
